// File: rtl/att_vol_ramp.sv
// Multi-channel volume attenuator with linear per-channel gain ramps and mute.
// One shared signed x unsigned multiplier is time-multiplexed, one channel per clock.
module att_vol_ramp #(
    parameter int BIT_WIDTH = 10,
    parameter int CH_NUM    = 4,
    parameter int GAIN_BITS = 10,
    parameter int INIT_GAIN = 1024,
    parameter int RAMP_STEP = 8,
    parameter int RAMP_DIV  = 64
) (
    input  logic                        CLK,
    input  logic                        RESET_n,
    input  logic                        IN_VALID,
    input  logic [CH_NUM*BIT_WIDTH-1:0] IN,
    input  logic                        GAIN_WE,
    input  logic [3:0]                  GAIN_CH,
    input  logic [GAIN_BITS:0]          GAIN_DATA,
    input  logic [CH_NUM-1:0]           MUTE,
    output logic [CH_NUM*BIT_WIDTH-1:0] OUT,
    output logic                        OUT_VALID,
    output logic                        BUSY,
    output logic                        OVERRUN,
    output logic                        SETTLED
);

    localparam int GW  = GAIN_BITS + 1;
    localparam int PW  = BIT_WIDTH + GAIN_BITS + 1;
    localparam int IW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PSW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [GW-1:0] UNITY = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GW-1:0] STEP  = GW'(RAMP_STEP);
    localparam logic [GW-1:0] INIT  = GW'(INIT_GAIN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic [GW-1:0]  target   [CH_NUM];
    logic [GW-1:0]  cur      [CH_NUM];
    logic [GW-1:0]  eff      [CH_NUM];
    logic [GW-1:0]  cur_next [CH_NUM];
    logic [PSW-1:0] presc;
    logic           tick;
    logic [GW-1:0]  gain_clamped;

    logic signed [BIT_WIDTH-1:0] frame_smp  [CH_NUM];
    logic [GW-1:0]               frame_gain [CH_NUM];
    logic [IW-1:0]               idx;
    logic                        last;

    logic signed [BIT_WIDTH-1:0] sel_smp;
    logic [GW-1:0]               sel_gain;
    logic signed [PW-1:0]        smp_ext, gain_ext, prod;
    logic signed [BIT_WIDTH-1:0] scaled;

    assign tick         = (presc == PSW'(RAMP_DIV - 1));
    assign gain_clamped = (GAIN_DATA > UNITY) ? UNITY : GAIN_DATA;
    assign last         = (idx == IW'(CH_NUM - 1));
    assign BUSY         = (state == RUN);

    // Each channel steps toward its effective target, landing exactly on it.
    always_comb begin
        SETTLED = 1'b1;
        for (int k = 0; k < CH_NUM; k++) begin
            eff[k]      = MUTE[k] ? '0 : target[k];
            cur_next[k] = cur[k];
            if (cur[k] > eff[k])
                cur_next[k] = ((cur[k] - eff[k]) <= STEP) ? eff[k] : cur[k] - STEP;
            else if (cur[k] < eff[k])
                cur_next[k] = ((eff[k] - cur[k]) <= STEP) ? eff[k] : cur[k] + STEP;
            if (cur[k] != eff[k])
                SETTLED = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            presc <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                target[k] <= INIT;
                cur[k]    <= INIT;
            end
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            for (int k = 0; k < CH_NUM; k++) begin
                if (GAIN_WE && (GAIN_CH == 4'(k)))
                    target[k] <= gain_clamped;
                if (tick)
                    cur[k] <= cur_next[k];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (IN_VALID) state_next = RUN;
            RUN:     if (last)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Floor division by unity: arithmetic shift of the signed product.
    always_comb begin
        sel_smp  = frame_smp[idx];
        sel_gain = frame_gain[idx];
        smp_ext  = PW'(sel_smp);
        gain_ext = PW'(sel_gain);
        prod     = smp_ext * gain_ext;
        scaled   = BIT_WIDTH'(prod >>> GAIN_BITS);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            idx       <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) begin
                frame_smp[k]  <= '0;
                frame_gain[k] <= '0;
            end
        end else begin
            OUT_VALID <= 1'b0;
            OVERRUN   <= (state == RUN) && IN_VALID;
            if ((state == IDLE) && IN_VALID) begin
                idx <= '0;
                for (int k = 0; k < CH_NUM; k++) begin
                    frame_smp[k]  <= IN[k*BIT_WIDTH +: BIT_WIDTH];
                    frame_gain[k] <= cur[k];
                end
            end
            if (state == RUN) begin
                OUT[idx*BIT_WIDTH +: BIT_WIDTH] <= scaled;
                idx <= idx + 1'b1;
                if (last)
                    OUT_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: doc/att_vol_ramp.md
Name: att_vol_ramp

Overview:
- Runtime-programmable, multi-channel volume attenuator for the audio mixing path, upstream of the DAC/PWM output stage.
- Per-channel gain is written at runtime as an unsigned fraction (2^GAIN_BITS = 0 dB).
- Applied gain ramps linearly toward the written target, with per-channel mute, to avoid zipper noise.
- One shared signed multiplier is time-multiplexed across all channels, one channel per clock.

Parameters:
- BIT_WIDTH, 10, signed sample width per channel.
- CH_NUM, 4, number of channels (1..16).
- GAIN_BITS, 10, gain fraction bits; unity gain = 2^GAIN_BITS.
- INIT_GAIN, 1024, reset value of target and current gain for every channel.
- RAMP_STEP, 8, gain LSBs moved per ramp tick (>=1).
- RAMP_DIV, 64, clocks per ramp tick (>=1).

Ports:
- CLK, in, 1, clock.
- RESET_n, in, 1, reset: asynchronous, active-low.
- IN_VALID, in, 1, one-cycle frame strobe; IN is sampled on this edge.
- IN, in, CH_NUM*BIT_WIDTH, packed signed samples; channel k occupies [k*BIT_WIDTH +: BIT_WIDTH].
- GAIN_WE, in, 1, target gain write strobe.
- GAIN_CH, in, 4, channel index for the write.
- GAIN_DATA, in, GAIN_BITS+1, unsigned target gain.
- MUTE, in, CH_NUM, per-channel mute (level).
- OUT, out, CH_NUM*BIT_WIDTH, attenuated samples, packed like IN; registered.
- OUT_VALID, out, 1, one-cycle pulse when the whole OUT frame has been updated.
- BUSY, out, 1, high while a frame is being processed.
- OVERRUN, out, 1, one-cycle pulse when IN_VALID is dropped.
- SETTLED, out, 1, high when every channel's current gain equals its effective target.

Behaviour:
- Reset:
  - OUT=0, OUT_VALID=0, BUSY=0, OVERRUN=0.
  - Target and current gain = INIT_GAIN for all channels; prescaler=0; state IDLE.
  - Reset asserted mid-frame discards the frame; no OUT_VALID follows release.
- Gain write (GAIN_WE):
  - target[GAIN_CH] <= min(GAIN_DATA, 2^GAIN_BITS).
  - GAIN_CH >= CH_NUM: write ignored.
  - A new target mid-ramp redirects the ramp from the current value; there is no jump.
- Effective target: MUTE[k] ? 0 : target[k].
- Ramp:
  - Prescaler counts 0..RAMP_DIV-1 and ticks on wrap.
  - On each tick every channel moves cur toward its effective target by RAMP_STEP, clamped at the target (no overshoot).
  - Deasserting MUTE ramps back up to target.
- SETTLED is combinational from the cur/target comparison and is evaluated after the tick update.
- FSM, IDLE -> RUN -> IDLE:
  - IDLE: IN_VALID latches all IN samples plus a snapshot of all cur gains; idx=0; go RUN.
  - Gain changes after latch do not affect the frame in flight.
  - RUN: one channel per cycle. OUT[idx] <= (signed sample * unsigned gain) >>> GAIN_BITS, arithmetic shift, floor toward -inf.
  - After idx=CH_NUM-1 return to IDLE and assert OUT_VALID for one cycle.
- Latency: IN_VALID at edge T; channel k written at edge T+1+k; OUT_VALID high in cycle T+CH_NUM+1 (edge T+CH_NUM). BUSY=1 exactly in RUN.
- A new IN_VALID is accepted in the OUT_VALID cycle (back-to-back frames, period CH_NUM+1).
- IN_VALID while BUSY: ignored; OVERRUN pulses next cycle; frame in flight unaffected.
- Width rules:
  - Multiplier operands: (BIT_WIDTH)-bit signed × (GAIN_BITS+1)-bit unsigned, product BIT_WIDTH+GAIN_BITS+1 signed.
  - gain <= unity guarantees no overflow; output takes the low BIT_WIDTH bits after the shift.
- Unwritten OUT channels hold their previous value between frames.
- Simultaneous events:
  - IN_VALID and GAIN_WE in the same cycle: the frame uses pre-write gains.
  - Ramp tick and IN_VALID in the same cycle: the frame uses pre-tick gains.

Test Plan:
- Bench setting: RAMP_STEP=64, RAMP_DIV=4.
- Unity pass-through: after reset, IN={-512,511,-100,100} (ch3..ch0) -> OUT identical; OUT_VALID in cycle T+5; BUSY high cycles T+1..T+4.
- Ramp and rounding: write ch0=512 -> cur steps 1024,960,...,512 over 8 ticks (32 clk) and SETTLED rises. Then ch0 IN=100 -> 50; IN=-101 -> -51 (floor).
- Mute: MUTE[1]=1 -> ch1 ramps 1024->0 in 16 ticks and OUT ch1=0. MUTE[1]=0 -> ramps back to 1024 and samples restored.
- Overrun: IN_VALID at T and T+2 -> second dropped, OVERRUN pulse at T+3, single OUT_VALID. IN_VALID at T+5 (the OUT_VALID cycle) -> accepted.
- Clamp/ignore: GAIN_DATA=2000 on ch2 -> target 1024. GAIN_CH=5 -> no channel changes.
- Reset mid-frame: assert RESET_n=0 at T+2 -> OUT=0, OUT_VALID never pulses, gains back to INIT_GAIN.
